data_path: RTL and testbench

DATA_PATH -- requirements
Module: data_path

---
 rtl/data_path_pkg.sv | 29 ++
 rtl/data_path_alu.sv | 58 +++++
 rtl/reg32.sv | 25 ++
 rtl/data_path.sv | 133 +++++++++++++
 tb/tb_data_path.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_path_pkg.sv
// Shared definitions for the data_path block: ALU opcodes, source constants and helpers.
package data_path_pkg;

  localparam int unsigned DW = 32;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_MUL  = 5'd2,
    ALU_DIV  = 5'd3,
    ALU_SHR  = 5'd4,
    ALU_SHRA = 5'd5,
    ALU_SHL  = 5'd6,
    ALU_ROR  = 5'd7,
    ALU_ROL  = 5'd8,
    ALU_AND  = 5'd9,
    ALU_OR   = 5'd10,
    ALU_NEG  = 5'd11,
    ALU_NOT  = 5'd12
  } alu_op_e;

  // No external input port exists yet, so the InPort source reads as a constant.
  localparam logic [DW-1:0] INPORT_VAL = '0;

  function automatic logic [DW-1:0] sext19(input logic [18:0] v);
    return {{13{v[18]}}, v};
  endfunction

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: A = Y, B = bus, 64-bit result. Only MUL and DIV use the upper half;
// DIV puts the quotient low and the remainder high.
module data_path_alu
  import data_path_pkg::*;
(
  input  logic [4:0]  alu_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] c_o
);

  logic [4:0]         sh;
  logic [5:0]         sh_inv;
  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] prod;
  logic signed [31:0] quot;
  logic signed [31:0] rem;
  logic [31:0]        sra_r;
  logic [31:0]        ror_r;
  logic [31:0]        rol_r;
  logic               b_zero;

  assign sh     = b_i[4:0];
  assign sh_inv = 6'd32 - {1'b0, sh};
  assign a_ext  = {{32{a_i[31]}}, a_i};
  assign b_ext  = {{32{b_i[31]}}, b_i};
  assign prod   = a_ext * b_ext;
  assign b_zero = (b_i == '0);
  // Divisor forced to 1 on zero so the divider never sees /0; the result is overridden below.
  assign quot   = $signed(a_i) / $signed(b_zero ? 32'd1 : b_i);
  assign rem    = $signed(a_i) % $signed(b_zero ? 32'd1 : b_i);
  assign sra_r  = $signed(a_i) >>> sh;
  // A shift of 32 yields zero, so a count of 0 leaves the operand intact.
  assign ror_r  = (a_i >> sh) | (a_i << sh_inv);
  assign rol_r  = (a_i << sh) | (a_i >> sh_inv);

  always_comb begin
    c_o = '0;
    case (alu_op_i)
      ALU_ADD:  c_o = {32'b0, a_i + b_i};
      ALU_SUB:  c_o = {32'b0, a_i - b_i};
      ALU_MUL:  c_o = prod;
      ALU_DIV:  c_o = b_zero ? {a_i, 32'hFFFF_FFFF} : {rem, quot};
      ALU_SHR:  c_o = {32'b0, a_i >> sh};
      ALU_SHRA: c_o = {32'b0, sra_r};
      ALU_SHL:  c_o = {32'b0, a_i << sh};
      ALU_ROR:  c_o = {32'b0, ror_r};
      ALU_ROL:  c_o = {32'b0, rol_r};
      ALU_AND:  c_o = {32'b0, a_i & b_i};
      ALU_OR:   c_o = {32'b0, a_i | b_i};
      ALU_NEG:  c_o = {32'b0, 32'd0 - b_i};
      ALU_NOT:  c_o = {32'b0, ~b_i};
      default:  c_o = '0;
    endcase
  end

endmodule

// File: rtl/reg32.sv
// Generic register with asynchronous active-high clear and load enable.
// Width defaults to 32; Z uses a single 64-bit instance.
module reg32 #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/data_path.sv
// Single-bus datapath: 16 GPRs, PC/IR/Y/Z/HI/LO/MAR/MDR, a 24-source priority bus mux and an ALU.
// Bus is combinational; all register updates on the rising clock edge, cleared asynchronously.
module data_path
  import data_path_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        R0in,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        R4in,
  input  logic        R5in,
  input  logic        R6in,
  input  logic        R7in,
  input  logic        R8in,
  input  logic        R9in,
  input  logic        R10in,
  input  logic        R11in,
  input  logic        R12in,
  input  logic        R13in,
  input  logic        R14in,
  input  logic        R15in,
  input  logic        R0out,
  input  logic        R1out,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        R4out,
  input  logic        R5out,
  input  logic        R6out,
  input  logic        R7out,
  input  logic        R8out,
  input  logic        R9out,
  input  logic        R10out,
  input  logic        R11out,
  input  logic        R12out,
  input  logic        R13out,
  input  logic        R14out,
  input  logic        R15out,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        Zin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        PCout,
  input  logic        MDRout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        InPortout,
  input  logic        Cout,
  input  logic        Read,
  input  logic [4:0]  ALU_op,
  input  logic [31:0] Mdatain,
  output logic [31:0] BusMuxOut_out
);

  logic [15:0] r_in;
  logic [15:0] r_out;
  logic [31:0] r_q [16];
  logic [31:0] pc_q, ir_q, y_q, hi_q, lo_q, mar_q, mdr_q, mdr_d;
  logic [63:0] z_q;
  logic [63:0] alu_c;
  logic [31:0] c_sext;
  logic [31:0] bus;
  logic        unused_ok;

  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  for (genvar g = 0; g < 16; g++) begin : g_gpr
    reg32 u_r (.clock(clock), .clear(clear), .en_i(r_in[g]), .d_i(bus), .q_o(r_q[g]));
  end

  assign mdr_d = Read ? Mdatain : bus;

  reg32 u_pc  (.clock(clock), .clear(clear), .en_i(PCin),  .d_i(bus),   .q_o(pc_q));
  reg32 u_ir  (.clock(clock), .clear(clear), .en_i(IRin),  .d_i(bus),   .q_o(ir_q));
  reg32 u_y   (.clock(clock), .clear(clear), .en_i(Yin),   .d_i(bus),   .q_o(y_q));
  reg32 u_hi  (.clock(clock), .clear(clear), .en_i(HIin),  .d_i(bus),   .q_o(hi_q));
  reg32 u_lo  (.clock(clock), .clear(clear), .en_i(LOin),  .d_i(bus),   .q_o(lo_q));
  reg32 u_mar (.clock(clock), .clear(clear), .en_i(MARin), .d_i(bus),   .q_o(mar_q));
  reg32 u_mdr (.clock(clock), .clear(clear), .en_i(MDRin), .d_i(mdr_d), .q_o(mdr_q));

  reg32 #(.W(64)) u_z (.clock(clock), .clear(clear), .en_i(Zin), .d_i(alu_c), .q_o(z_q));

  data_path_alu u_alu (
    .alu_op_i (ALU_op),
    .a_i      (y_q),
    .b_i      (bus),
    .c_o      (alu_c)
  );

  assign c_sext = sext19(ir_q[18:0]);

  // GPRs have highest priority, lowest index first; then the special sources in fixed order.
  always_comb begin
    bus = '0;
    if (|r_out) begin
      for (int i = 15; i >= 0; i--) begin
        if (r_out[i]) bus = r_q[i];
      end
    end else if (HIout) begin
      bus = hi_q;
    end else if (LOout) begin
      bus = lo_q;
    end else if (Zhighout) begin
      bus = z_q[63:32];
    end else if (Zlowout) begin
      bus = z_q[31:0];
    end else if (PCout) begin
      bus = pc_q;
    end else if (MDRout) begin
      bus = mdr_q;
    end else if (InPortout) begin
      bus = INPORT_VAL;
    end else if (Cout) begin
      bus = c_sext;
    end
  end

  assign BusMuxOut_out = bus;

  // MAR feeds the memory interface of a later phase; IR's upper bits feed the future decoder.
  assign unused_ok = &{1'b0, mar_q, ir_q[31:19]};

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: tasks drive bus transfers and push expected bus values;
// a monitor pops and compares whenever a check strobe fires.
module tb_data_path;
  import data_path_pkg::*;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [23:0] sel = '0;  // 0-15 Rn, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C
  logic [23:0] ld  = '0;  // 0-15 Rn, 16 HI, 17 LO, 18 PC, 19 IR, 20 Y, 21 Z, 22 MAR, 23 MDR
  logic        Read = 1'b0;
  logic [4:0]  ALU_op = '0;
  logic [31:0] Mdatain = '0;
  logic [31:0] BusMuxOut_out;

  always #5 clock = ~clock;

  data_path dut (
    .clock(clock), .clear(clear),
    .R0in(ld[0]), .R1in(ld[1]), .R2in(ld[2]), .R3in(ld[3]),
    .R4in(ld[4]), .R5in(ld[5]), .R6in(ld[6]), .R7in(ld[7]),
    .R8in(ld[8]), .R9in(ld[9]), .R10in(ld[10]), .R11in(ld[11]),
    .R12in(ld[12]), .R13in(ld[13]), .R14in(ld[14]), .R15in(ld[15]),
    .R0out(sel[0]), .R1out(sel[1]), .R2out(sel[2]), .R3out(sel[3]),
    .R4out(sel[4]), .R5out(sel[5]), .R6out(sel[6]), .R7out(sel[7]),
    .R8out(sel[8]), .R9out(sel[9]), .R10out(sel[10]), .R11out(sel[11]),
    .R12out(sel[12]), .R13out(sel[13]), .R14out(sel[14]), .R15out(sel[15]),
    .PCin(ld[18]), .IRin(ld[19]), .Yin(ld[20]), .Zin(ld[21]),
    .HIin(ld[16]), .LOin(ld[17]), .MARin(ld[22]), .MDRin(ld[23]),
    .PCout(sel[20]), .MDRout(sel[21]), .Zhighout(sel[18]), .Zlowout(sel[19]),
    .HIout(sel[16]), .LOout(sel[17]), .InPortout(sel[22]), .Cout(sel[23]),
    .Read(Read), .ALU_op(ALU_op), .Mdatain(Mdatain),
    .BusMuxOut_out(BusMuxOut_out)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo, m_pc, m_ir, m_y, m_mar, m_mdr;
  logic [63:0] m_z;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_hi = '0; m_lo = '0; m_pc = '0; m_ir = '0; m_y = '0; m_mar = '0; m_mdr = '0; m_z = '0;
  endtask

  function automatic logic [31:0] src_val(input int s);
    if (s < 16) return m_r[s];
    case (s)
      16: return m_hi;
      17: return m_lo;
      18: return m_z[63:32];
      19: return m_z[31:0];
      20: return m_pc;
      21: return m_mdr;
      22: return 32'd0;
      23: return {{13{m_ir[18]}}, m_ir[18:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] bus_model(input logic [23:0] s);
    for (int i = 0; i < 24; i++) if (s[i]) return src_val(i);
    return 32'd0;
  endfunction

  task automatic model_write(input int d, input logic [31:0] v);
    if (d < 16) m_r[d] = v;
    else case (d)
      16: m_hi = v;
      17: m_lo = v;
      18: m_pc = v;
      19: m_ir = v;
      20: m_y = v;
      22: m_mar = v;
      23: m_mdr = v;
      default: ;
    endcase
  endtask

  function automatic logic [63:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb, n;
    longint      p, ma, mb, q, r;
    logic [31:0] res;
    sa = a; sb = b; n = int'(b[4:0]); res = a;
    case (op)
      0: return {32'd0, a + b};
      1: return {32'd0, a - b};
      2: begin p = longint'(sa) * longint'(sb); return p; end
      3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        ma = (sa < 0) ? -longint'(sa) : longint'(sa);
        mb = (sb < 0) ? -longint'(sb) : longint'(sb);
        q = ma / mb; r = ma - q * mb;
        if ((sa < 0) != (sb < 0)) q = -q;
        if (sa < 0) r = -r;
        return {r[31:0], q[31:0]};
      end
      4: return {32'd0, a >> n};
      5: begin repeat (n) res = {res[31], res[31:1]}; return {32'd0, res}; end
      6: return {32'd0, a << n};
      7: begin repeat (n) res = {res[0], res[31:1]}; return {32'd0, res}; end
      8: begin repeat (n) res = {res[30:0], res[31]}; return {32'd0, res}; end
      9: return {32'd0, a & b};
      10: return {32'd0, a | b};
      11: return {32'd0, 32'd0 - b};
      12: return {32'd0, ~b};
      default: return 64'd0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [$];
  string       nm_q [$];
  event        chk_ev;
  int          n_tests = 0;
  int          n_fail  = 0;

  initial begin
    logic [31:0] got, e;
    string nm;
    forever begin
      @(chk_ev);
      got = BusMuxOut_out;
      e = exp_q.pop_front();
      nm = nm_q.pop_front();
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: bus=%08h expected=%08h", nm, got, e);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    ->chk_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic show(input int s, input string nm);
    sel = 24'(1) << s;
    #1;
    check(nm, src_val(s));
    sel = '0;
  endtask

  task automatic show_const(input int s, input string nm, input logic [31:0] e);
    sel = 24'(1) << s;
    #1;
    check(nm, e);
    sel = '0;
  endtask

  task automatic xfer(input int s, input int d);
    logic [31:0] v;
    sel = 24'(1) << s;
    ld  = 24'(1) << d;
    v = bus_model(sel);
    tick();
    model_write(d, v);
    sel = '0; ld = '0;
  endtask

  task automatic load_reg(input int n, input logic [31:0] v);
    Mdatain = v; Read = 1'b1; ld = 24'(1) << 23;
    tick();
    m_mdr = v;
    Read = 1'b0; ld = '0;
    xfer(21, n);
  endtask

  task automatic run_alu(input int op, input int ra, input int rb, input int dl, input int dh);
    xfer(ra, 20);
    sel = 24'(1) << rb; ALU_op = 5'(op); ld = 24'(1) << 21;
    tick();
    m_z = ref_alu(op, m_y, m_r[rb]);
    sel = '0; ld = '0; ALU_op = '0;
    xfer(19, dl);
    xfer(18, dh);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, b;
    int op;
    model_reset();
    #1;
    check("idle_bus", 32'd0);
    for (int s = 0; s < 24; s++) show_const(s, "reset_src", 32'd0);
    tick();
    clear = 1'b0;
    tick();

    load_reg(5, 32'h34); load_reg(6, 32'h45);
    show_const(5, "ld_r5", 32'h34);
    run_alu(ALU_AND, 5, 6, 7, 12); show_const(7, "and", 32'h0000_0004);
    run_alu(ALU_OR,  5, 6, 7, 12); show_const(7, "or",  32'h0000_0075);
    load_reg(8, 32'h10); load_reg(9, 32'h05);
    run_alu(ALU_ADD, 8, 9, 7, 12); show_const(7, "add", 32'h15);
    show_const(12, "add_hi0", 32'h0);
    run_alu(ALU_SUB, 8, 9, 7, 12); show_const(7, "sub", 32'h0B);

    load_reg(1, 32'd7); load_reg(2, 32'd3);
    run_alu(ALU_MUL, 1, 2, 17, 16);
    show_const(17, "mul_lo", 32'h15); show_const(16, "mul_hi", 32'h0);
    load_reg(1, 32'h14);
    run_alu(ALU_DIV, 1, 2, 17, 16);
    show_const(17, "div_lo", 32'd6); show_const(16, "div_hi", 32'd2);
    load_reg(2, 32'd0);
    run_alu(ALU_DIV, 1, 2, 17, 16);
    show_const(17, "div0_lo", 32'hFFFF_FFFF); show_const(16, "div0_hi", 32'h14);

    load_reg(2, 32'd9);
    run_alu(ALU_NEG, 1, 2, 7, 12); show_const(7, "neg", 32'hFFFF_FFF7);
    show_const(12, "neg_hi0", 32'h0);
    load_reg(2, 32'h0F);
    run_alu(ALU_NOT, 1, 2, 7, 12); show_const(7, "not", 32'hFFFF_FFF0);

    load_reg(1, 32'h10); load_reg(2, 32'd2);
    run_alu(ALU_SHR, 1, 2, 7, 12); show_const(7, "shr", 32'h4);
    load_reg(1, 32'h8000_0000); load_reg(2, 32'd1);
    run_alu(ALU_SHRA, 1, 2, 7, 12); show_const(7, "shra", 32'hC000_0000);
    load_reg(1, 32'd1); load_reg(2, 32'd3);
    run_alu(ALU_SHL, 1, 2, 7, 12); show_const(7, "shl", 32'h8);
    load_reg(1, 32'h8000_0001); load_reg(2, 32'd1);
    run_alu(ALU_ROR, 1, 2, 7, 12); show_const(7, "ror", 32'hC000_0000);
    run_alu(ALU_ROL, 1, 2, 7, 12); show_const(7, "rol", 32'h0000_0003);
    load_reg(2, 32'd0);
    run_alu(ALU_ROR, 1, 2, 7, 12); show_const(7, "ror0", 32'h8000_0001);

    // Priority: R3 beats R5 and HI; InPort constant; C sign extension of IR[18:0].
    load_reg(3, 32'hAAAA_0003); load_reg(5, 32'h5555_0005);
    sel = (24'(1) << 3) | (24'(1) << 5) | (24'(1) << 16);
    #1; check("prio", 32'hAAAA_0003); sel = '0;
    show_const(22, "inport", 32'h0);
    load_reg(0, 32'h0004_0001); xfer(0, 19);
    show_const(23, "c_neg", 32'hFFFC_0001);
    load_reg(0, 32'hFFF3_0005); xfer(0, 19);
    show_const(23, "c_pos", 32'h0003_0005);
    show(0, "r0_plain");

    // MDR driving the bus while loading from memory: old value seen, new value captured.
    sel = 24'(1) << 21; ld = 24'(1) << 23; Read = 1'b1; Mdatain = 32'hABCD_0123;
    #1; check("mdr_old", 32'hFFF3_0005);
    tick(); m_mdr = 32'hABCD_0123;
    check("mdr_new", 32'hABCD_0123);
    sel = '0; ld = '0; Read = 1'b0;

    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 15);
      a = $urandom; b = $urandom;
      if (op == 3 && $urandom_range(0, 3) == 0) b = 32'd0;
      if (op == 3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      load_reg(1, a); load_reg(2, b);
      run_alu(op, 1, 2, 10, 11);
      show(10, "rand_lo"); show(11, "rand_hi");
    end

    // Clear asserted mid-transfer discards it and zeroes everything at once.
    load_reg(3, 32'hDEAD_0003); load_reg(4, 32'hBEEF_0004);
    sel = 24'(1) << 3; ld = 24'(1) << 20;
    #2; clear = 1'b1; #1;
    check("clr_async", 32'd0);
    @(posedge clock); #1;
    sel = '0; ld = '0; clear = 1'b0;
    model_reset();
    tick();
    for (int s = 0; s < 24; s++) show(s, "post_clear");
    ld = 24'(1) << 21; ALU_op = 5'(ALU_ADD);
    tick();
    ld = '0;
    show_const(19, "y_cleared", 32'd0);

    tick();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d checks left unserviced, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
